// File: rtl/controle_irrigacao.sv
// Irrigation cycle sequencer: loads a BCD mm:ss preset, checks the tank level and
// counts down on tick_1hz while driving one valve. Optional pause: CONTROLE_PAUSA_EN.
module controle_irrigacao (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       iniciar,
  input  logic       parar,
  input  logic       aspersao,
  input  logic       gotejamento,
  input  logic [2:0] niveis,
  input  logic [3:0] dez_minutopreset,
  input  logic [3:0] unid_minutopreset,
  input  logic [3:0] dez_segundopreset,
  input  logic [3:0] unid_segundopreset,
  output logic [3:0] dez_minuto,
  output logic [3:0] unid_minuto,
  output logic [3:0] dez_segundo,
  output logic [3:0] unid_segundo,
  output logic       valvula_aspersao,
  output logic       valvula_gotejamento,
  output logic       ativo,
  output logic       fim,
  output logic       erro
);

  typedef enum logic [2:0] {OCIOSO, CARREGA, CONTANDO, PAUSA, ERRO} estado_t;

  estado_t     estado_q, estado_d;
  logic        modo_q, modo_d;       // 1: aspersao, 0: gotejamento
  logic        iniciar_q;
  logic [15:0] cnt_q, cnt_d;
  logic        valv_asp_q, valv_asp_d, valv_got_q, valv_got_d;
  logic        ativo_q, ativo_d, fim_q, fim_d, erro_q, erro_d;
`ifdef CONTROLE_PAUSA_EN
  logic        pausa_seg_q, pausa_seg_d;
`endif

  logic        ini_rise, nivel_ok, preset_ok;
  logic [15:0] preset, cnt_dec;

  assign ini_rise = iniciar & ~iniciar_q;
  assign preset   = {dez_minutopreset, unid_minutopreset, dez_segundopreset, unid_segundopreset};
  assign preset_ok = (dez_minutopreset <= 4'd9) && (unid_minutopreset <= 4'd9) &&
                     (dez_segundopreset <= 4'd5) && (unid_segundopreset <= 4'd9);
  assign nivel_ok = ((niveis == 3'b000) || (niveis == 3'b001) ||
                     (niveis == 3'b011) || (niveis == 3'b111)) &&
                    (modo_q ? niveis[1] : niveis[0]);

  // BCD mm:ss decrement with borrow through 9/5/9
  always_comb begin
    cnt_dec = cnt_q;
    if (cnt_q[3:0] != 4'd0) begin
      cnt_dec[3:0] = cnt_q[3:0] - 4'd1;
    end else begin
      cnt_dec[3:0] = 4'd9;
      if (cnt_q[7:4] != 4'd0) begin
        cnt_dec[7:4] = cnt_q[7:4] - 4'd1;
      end else begin
        cnt_dec[7:4] = 4'd5;
        if (cnt_q[11:8] != 4'd0) begin
          cnt_dec[11:8] = cnt_q[11:8] - 4'd1;
        end else begin
          cnt_dec[11:8]  = 4'd9;
          cnt_dec[15:12] = cnt_q[15:12] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    estado_d = estado_q;
    modo_d   = modo_q;
    cnt_d    = cnt_q;
    fim_d    = 1'b0;
`ifdef CONTROLE_PAUSA_EN
    pausa_seg_d = pausa_seg_q;
`endif
    case (estado_q)
      OCIOSO: begin
        if (ini_rise && !parar) begin
          if (aspersao) begin
            modo_d   = 1'b1;
            estado_d = CARREGA;
          end else if (gotejamento) begin
            modo_d   = 1'b0;
            estado_d = CARREGA;
          end else begin
            estado_d = ERRO;
          end
        end
      end
      CARREGA: begin
        cnt_d = preset;
        if (!preset_ok || !nivel_ok) begin
          cnt_d    = 16'h0000;
          estado_d = ERRO;
        end else if (preset == 16'h0000) begin
          fim_d    = 1'b1;
          estado_d = OCIOSO;
        end else begin
          estado_d = CONTANDO;
        end
      end
      CONTANDO: begin
        if (!nivel_ok) begin
          cnt_d    = 16'h0000;
          estado_d = ERRO;
        end else if (parar) begin
`ifdef CONTROLE_PAUSA_EN
          pausa_seg_d = 1'b0;
          estado_d    = PAUSA;
`else
          cnt_d    = 16'h0000;
          estado_d = OCIOSO;
`endif
        end else if (tick_1hz) begin
          cnt_d = cnt_dec;
          if (cnt_dec == 16'h0000) begin
            fim_d    = 1'b1;
            estado_d = OCIOSO;
          end
        end
      end
`ifdef CONTROLE_PAUSA_EN
      PAUSA: begin
        if (ini_rise) begin
          if (nivel_ok) begin
            estado_d = CONTANDO;
          end else begin
            cnt_d    = 16'h0000;
            estado_d = ERRO;
          end
        end else if (!parar) begin
          pausa_seg_d = 1'b0;
        end else if (tick_1hz) begin
          // second consecutive tick with parar held abandons the cycle
          if (pausa_seg_q) begin
            cnt_d    = 16'h0000;
            estado_d = OCIOSO;
          end else begin
            pausa_seg_d = 1'b1;
          end
        end
      end
`endif
      ERRO: begin
        cnt_d = 16'h0000;
        if (parar && !iniciar) estado_d = OCIOSO;
      end
      default: begin
        cnt_d    = 16'h0000;
        estado_d = OCIOSO;
      end
    endcase

    valv_asp_d = (estado_d == CONTANDO) &&  modo_d;
    valv_got_d = (estado_d == CONTANDO) && !modo_d;
    ativo_d    = (estado_d == CONTANDO) || (estado_d == PAUSA);
    erro_d     = (estado_d == ERRO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= OCIOSO;
      modo_q     <= 1'b0;
      iniciar_q  <= 1'b1;  // a level already high out of reset is not an edge
      cnt_q      <= 16'h0000;
      valv_asp_q <= 1'b0;
      valv_got_q <= 1'b0;
      ativo_q    <= 1'b0;
      fim_q      <= 1'b0;
      erro_q     <= 1'b0;
`ifdef CONTROLE_PAUSA_EN
      pausa_seg_q <= 1'b0;
`endif
    end else begin
      estado_q   <= estado_d;
      modo_q     <= modo_d;
      iniciar_q  <= iniciar;
      cnt_q      <= cnt_d;
      valv_asp_q <= valv_asp_d;
      valv_got_q <= valv_got_d;
      ativo_q    <= ativo_d;
      fim_q      <= fim_d;
      erro_q     <= erro_d;
`ifdef CONTROLE_PAUSA_EN
      pausa_seg_q <= pausa_seg_d;
`endif
    end
  end

  assign {dez_minuto, unid_minuto, dez_segundo, unid_segundo} = cnt_q;
  assign valvula_aspersao    = valv_asp_q;
  assign valvula_gotejamento = valv_got_q;
  assign ativo = ativo_q;
  assign fim   = fim_q;
  assign erro  = erro_q;

endmodule

// File: tb/tb_controle_irrigacao.sv
// Directed bench for controle_irrigacao; expected values hand-computed per scenario.
module tb_controle_irrigacao;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0, iniciar = 1'b0, parar = 1'b0;
  logic       aspersao = 1'b0, gotejamento = 1'b0;
  logic [2:0] niveis = 3'b000;
  logic [3:0] dmp = 4'd0, ump = 4'd0, dsp = 4'd0, usp = 4'd0;
  logic [3:0] dm, um, ds, us;
  logic       v_asp, v_got, ativo, fim, erro;
  int         vectors = 0;
  int         fails = 0;

  controle_irrigacao dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .iniciar(iniciar), .parar(parar),
    .aspersao(aspersao), .gotejamento(gotejamento), .niveis(niveis),
    .dez_minutopreset(dmp), .unid_minutopreset(ump),
    .dez_segundopreset(dsp), .unid_segundopreset(usp),
    .dez_minuto(dm), .unid_minuto(um), .dez_segundo(ds), .unid_segundo(us),
    .valvula_aspersao(v_asp), .valvula_gotejamento(v_got),
    .ativo(ativo), .fim(fim), .erro(erro)
  );

  always #5 clk = ~clk;

  wire [15:0] cnt  = {dm, um, ds, us};
  wire [4:0]  outs = {v_asp, v_got, ativo, fim, erro};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic set_preset(input logic [15:0] p);
    {dmp, ump, dsp, usp} = p;
  endtask

  task automatic do_reset();
    iniciar = 1'b0; parar = 1'b0; tick_1hz = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  // iniciar rises before edge N; returns after edge N+1
  task automatic start();
    iniciar = 1'b1;
    step();
    step();
    iniciar = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vectors++;
    if ({cnt, outs} !== 21'h0) begin
      fails++; $display("FAIL reset: cnt=%h outs=%b expected 0000/00000", cnt, outs);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_drip_countdown();
    set_preset(16'h0003); gotejamento = 1'b1; aspersao = 1'b0; niveis = 3'b001;
    step();
    iniciar = 1'b1;
    step();
    vectors++;
    if (outs !== 5'b00000) begin
      fails++; $display("FAIL drip_carrega: outs=%b expected 00000", outs);
    end
    step();
    iniciar = 1'b0;
    vectors++;
    if ({cnt, outs} !== {16'h0003, 5'b01100}) begin
      fails++; $display("FAIL drip_start: cnt=%h outs=%b expected 0003/01100", cnt, outs);
    end
    pulse_tick();
    vectors++;
    if (cnt !== 16'h0002) begin
      fails++; $display("FAIL drip_t1: cnt=%h expected 0002", cnt);
    end
    step();
    vectors++;
    if (cnt !== 16'h0002) begin
      fails++; $display("FAIL drip_no_tick: cnt=%h expected 0002", cnt);
    end
    pulse_tick();
    vectors++;
    if ({cnt, outs} !== {16'h0001, 5'b01100}) begin
      fails++; $display("FAIL drip_t2: cnt=%h outs=%b expected 0001/01100", cnt, outs);
    end
    pulse_tick();
    vectors++;
    if ({cnt, outs} !== {16'h0000, 5'b00010}) begin
      fails++; $display("FAIL drip_done: cnt=%h outs=%b expected 0000/00010", cnt, outs);
    end
    step();
    vectors++;
    if (outs !== 5'b00000) begin
      fails++; $display("FAIL drip_fim_once: outs=%b expected 00000", outs);
    end
  endtask

  task automatic test_borrow_chain();
    do_reset();
    set_preset(16'h1000); aspersao = 1'b1; gotejamento = 1'b1; niveis = 3'b011;
    start();
    vectors++;
    if ({cnt, outs} !== {16'h1000, 5'b10100}) begin
      fails++; $display("FAIL sprk_start: cnt=%h outs=%b expected 1000/10100", cnt, outs);
    end
    pulse_tick();
    vectors++;
    if ({cnt, outs} !== {16'h0959, 5'b10100}) begin
      fails++; $display("FAIL borrow: cnt=%h outs=%b expected 0959/10100", cnt, outs);
    end
    pulse_tick();
    vectors++;
    if (cnt !== 16'h0958) begin
      fails++; $display("FAIL borrow2: cnt=%h expected 0958", cnt);
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({cnt, outs} !== 21'h0) begin
      fails++; $display("FAIL async_reset: cnt=%h outs=%b expected 0000/00000", cnt, outs);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_level_fault_start();
    do_reset();
    set_preset(16'h0100); aspersao = 1'b1; gotejamento = 1'b0; niveis = 3'b001;
    start();
    vectors++;
    if ({cnt, outs} !== {16'h0000, 5'b00001}) begin
      fails++; $display("FAIL lvl_start: cnt=%h outs=%b expected 0000/00001", cnt, outs);
    end
    iniciar = 1'b1; parar = 1'b1;
    step();
    vectors++;
    if (erro !== 1'b1) begin
      fails++; $display("FAIL erro_hold_iniciar: erro=%b expected 1", erro);
    end
    iniciar = 1'b0;
    step();
    parar = 1'b0;
    vectors++;
    if (outs !== 5'b00000) begin
      fails++; $display("FAIL erro_exit: outs=%b expected 00000", outs);
    end
  endtask

  task automatic test_priority_fault();
    do_reset();
    set_preset(16'h0010); aspersao = 1'b1; gotejamento = 1'b0; niveis = 3'b011;
    start();
    pulse_tick();
    vectors++;
    if (cnt !== 16'h0009) begin
      fails++; $display("FAIL prio_pre: cnt=%h expected 0009", cnt);
    end
    niveis = 3'b010; tick_1hz = 1'b1; parar = 1'b1;
    step();
    tick_1hz = 1'b0; parar = 1'b0;
    vectors++;
    if ({cnt, outs} !== {16'h0000, 5'b00001}) begin
      fails++; $display("FAIL prio_fault: cnt=%h outs=%b expected 0000/00001", cnt, outs);
    end
  endtask

  task automatic test_bad_preset_and_zero();
    do_reset();
    set_preset(16'h0060); aspersao = 1'b0; gotejamento = 1'b1; niveis = 3'b111;
    start();
    vectors++;
    if (outs !== 5'b00001) begin
      fails++; $display("FAIL bad_preset: outs=%b expected 00001", outs);
    end
    do_reset();
    set_preset(16'h0000);
    start();
    vectors++;
    if ({cnt, outs} !== {16'h0000, 5'b00010}) begin
      fails++; $display("FAIL zero_preset: cnt=%h outs=%b expected 0000/00010", cnt, outs);
    end
    step();
    vectors++;
    if (outs !== 5'b00000) begin
      fails++; $display("FAIL zero_after: outs=%b expected 00000", outs);
    end
  endtask

  task automatic test_no_mode_and_held_start();
    do_reset();
    set_preset(16'h0005); aspersao = 1'b0; gotejamento = 1'b0; niveis = 3'b111;
    iniciar = 1'b1;
    step();
    vectors++;
    if (outs !== 5'b00001) begin
      fails++; $display("FAIL no_mode: outs=%b expected 00001", outs);
    end
    gotejamento = 1'b1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    step(); step(); step();
    vectors++;
    if (outs !== 5'b00000) begin
      fails++; $display("FAIL held_iniciar: outs=%b expected 00000", outs);
    end
    iniciar = 1'b0;
  endtask

  task automatic test_parar();
    do_reset();
    set_preset(16'h0007); aspersao = 1'b0; gotejamento = 1'b1; niveis = 3'b001;
    start();
    pulse_tick(); pulse_tick();
    vectors++;
    if (cnt !== 16'h0005) begin
      fails++; $display("FAIL parar_pre: cnt=%h expected 0005", cnt);
    end
    parar = 1'b1;
    step();
    parar = 1'b0;
`ifdef CONTROLE_PAUSA_EN
    vectors++;
    if ({cnt, outs} !== {16'h0005, 5'b00100}) begin
      fails++; $display("FAIL pause: cnt=%h outs=%b expected 0005/00100", cnt, outs);
    end
    pulse_tick(); pulse_tick();
    vectors++;
    if ({cnt, outs} !== {16'h0005, 5'b00100}) begin
      fails++; $display("FAIL pause_frozen: cnt=%h outs=%b expected 0005/00100", cnt, outs);
    end
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    vectors++;
    if ({cnt, outs} !== {16'h0005, 5'b01100}) begin
      fails++; $display("FAIL resume: cnt=%h outs=%b expected 0005/01100", cnt, outs);
    end
    pulse_tick();
    vectors++;
    if (cnt !== 16'h0004) begin
      fails++; $display("FAIL resume_tick: cnt=%h expected 0004", cnt);
    end
    parar = 1'b1;
    step(); pulse_tick(); pulse_tick();
    parar = 1'b0;
    vectors++;
    if ({cnt, outs} !== {16'h0000, 5'b00000}) begin
      fails++; $display("FAIL pause_abort: cnt=%h outs=%b expected 0000/00000", cnt, outs);
    end
`else
    vectors++;
    if ({cnt, outs} !== {16'h0000, 5'b00000}) begin
      fails++; $display("FAIL abort: cnt=%h outs=%b expected 0000/00000", cnt, outs);
    end
    pulse_tick();
    vectors++;
    if ({cnt, outs} !== {16'h0000, 5'b00000}) begin
      fails++; $display("FAIL abort_idle: cnt=%h outs=%b expected 0000/00000", cnt, outs);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_drip_countdown();
    test_borrow_chain();
    test_async_reset();
    test_level_fault_start();
    test_priority_fault();
    test_bad_preset_and_zero();
    test_no_mode_and_held_start();
    test_parar();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/controle_irrigacao.md
# controle_irrigacao

Sequencer for one irrigation cycle. It loads the BCD preset time (mm:ss digits from the preset generator) into a countdown and validates the tank level for the selected mode. It drives the sprinkler or drip valve while counting down on a 1 Hz tick, and reports completion or fault. It sits between the preset generator, the level sensors and the valve/display outputs.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick_1hz  in  1  one-cycle enable pulse, once per second
- iniciar  in  1  start request (level; rising edge detected internally)
- parar  in  1  stop/abort request (level)
- aspersao  in  1  sprinkler mode select
- gotejamento  in  1  drip mode select
- niveis  in  3  tank level, thermometer code: [0] low, [1] mid, [2] high
- dez_minutopreset, unid_minutopreset, dez_segundopreset, unid_segundopreset  in  4 each  BCD preset
- dez_minuto, unid_minuto, dez_segundo, unid_segundo  out  4 each  remaining time, BCD
- valvula_aspersao  out  1  sprinkler valve open
- valvula_gotejamento  out  1  drip valve open
- ativo  out  1  high while in CONTANDO (or PAUSA)
- fim  out  1  one-cycle pulse on normal completion
- erro  out  1  high while in ERRO

## Operation
- States: OCIOSO, CARREGA, CONTANDO, PAUSA (macro only), ERRO.
- OCIOSO -> CARREGA on the iniciar rising edge with parar low. The block registers the mode at that edge: aspersao has priority over gotejamento.
- OCIOSO with neither mode selected at the iniciar edge -> ERRO.
- CARREGA, one cycle:
  - copies the preset into the counter;
  - invalid preset (any digit >9, or dez_segundopreset >5) -> ERRO;
  - level insufficient -> ERRO;
  - preset 00:00 -> fim pulse, then OCIOSO;
  - otherwise -> CONTANDO.
- Level requirement:
  - niveis must be a valid thermometer code (000, 001, 011, 111); other codes are a fault.
  - aspersao needs niveis[1]=1; gotejamento needs niveis[0]=1.
- CONTANDO: the count decrements on each tick_1hz. Borrow chain:
  - unid_segundo 0 -> 9;
  - dez_segundo 0 -> 5;
  - unid_minuto 0 -> 9;
  - dez_minuto -1.
- CONTANDO exits:
  - the decrement that yields 00:00 -> fim pulse, valves off, OCIOSO; the display holds 00:00.
  - level insufficient or invalid, checked every cycle -> ERRO.
  - parar -> OCIOSO (without macro), with the counter cleared to 00:00.
- ERRO: valves closed and the counter cleared. Exits to OCIOSO only when parar=1 and iniciar=0.
- Valves open only in CONTANDO, and only the valve for the registered mode. Never both.
- The iniciar edge detector ignores edges outside OCIOSO. A level held high since reset does not start a cycle.

## Timing
- All outputs are registered.
- Reset values: counter digits 0000, both valves 0, ativo 0, fim 0, erro 0, state OCIOSO.
- Start latency:
  - iniciar rises in cycle N (sampled at edge N);
  - CARREGA in cycle N+1;
  - CONTANDO, with valve and ativo high, from cycle N+2.
- The counter updates the cycle after tick_1hz is sampled. A tick in CARREGA is ignored.
- The valve closes and fim pulses in the same cycle the counter shows 00:00.
- Simultaneous events in one cycle, priority: level fault > parar > tick.
- rst_n assertion mid-cycle forces reset values immediately (asynchronous). Deassertion is expected synchronous to clk.

## Configuration
- Macro: CONTROLE_PAUSA_EN.
- Defined:
  - parar in CONTANDO -> PAUSA: valves closed, counter held, ativo stays 1, ticks ignored.
  - A new iniciar rising edge in PAUSA resumes CONTANDO, after re-checking the level (fault -> ERRO).
  - parar held for 2 or more consecutive seconds (tick_1hz pulses) in PAUSA -> OCIOSO with the counter cleared.
- Undefined: PAUSA does not exist; parar in CONTANDO aborts to OCIOSO.

## Test plan
- Preset 00:03, gotejamento=1, niveis=001, iniciar pulse, then 3 ticks -> valvula_gotejamento=1 from cycle N+2; count 00:02, 00:01, 00:00; fim pulses once; valve 0.
- Preset 10:00, aspersao=1, niveis=011, one tick -> count shows 09:59 (full borrow chain); valvula_aspersao=1, valvula_gotejamento=0.
- aspersao=1, niveis=001 at start -> ERRO in cycle N+2 and valves never open; then parar=1 with iniciar=0 -> OCIOSO.
- Mid-count, niveis changes 011 -> 010 in the same cycle as tick and parar -> ERRO; count not decremented; valves 0 next cycle.
- Preset dez_segundopreset=0110 -> ERRO from CARREGA. Preset 00:00 -> fim pulse with no valve activity.
- With CONTROLE_PAUSA_EN: parar at 00:05 -> valve 0 and count frozen across ticks; iniciar edge -> resumes at 00:05. Without the macro: parar -> OCIOSO with count 00:00.
